// File: rtl/arp_receiver.sv
// ARP frame receiver: validates an Ethernet/ARP header byte stream against the local
// MAC/IP, checks the CRC-32 FCS and length, and reports the sender of accepted frames.
module arp_receiver #(
    parameter logic [47:0] LOCAL_MAC = 48'h000000000000,
    parameter logic [31:0] LOCAL_IP  = 32'h00000000
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        rx_en,
    input  logic [7:0]  rx_data,
    input  logic        rx_last,
    output logic        arp_valid,
    output logic        arp_is_req,
    output logic [47:0] peer_mac,
    output logic [31:0] peer_ip,
    output logic        drop
);

    typedef enum logic [1:0] {IDLE, HDR, TAIL, DROP} state_t;

    state_t      state_q, state_d;
    logic [10:0] n_q, n_d;
    logic [31:0] crc_q, crc_d;
    logic [47:0] sha_q, sha_d;
    logic [31:0] spa_q, spa_d;
    logic        req_q, req_d;
    logic        bc_q, bc_d;
    logic        uc_q, uc_d;
    logic        arp_valid_q, arp_valid_d;
    logic        drop_q, drop_d;
    logic        is_req_q, is_req_d;
    logic [47:0] peer_mac_q, peer_mac_d;
    logic [31:0] peer_ip_q, peer_ip_d;

    logic [31:0] crc_next;
    logic [7:0]  mac_byte;
    logic [7:0]  ip_byte;
    logic        field_ok;
    logic        bc_now;
    logic        uc_now;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    // Local address byte expected at the current header position.
    always_comb begin
        case (n_q[2:0])
            3'd0:    mac_byte = LOCAL_MAC[47:40];
            3'd1:    mac_byte = LOCAL_MAC[39:32];
            3'd2:    mac_byte = LOCAL_MAC[31:24];
            3'd3:    mac_byte = LOCAL_MAC[23:16];
            3'd4:    mac_byte = LOCAL_MAC[15:8];
            3'd5:    mac_byte = LOCAL_MAC[7:0];
            default: mac_byte = 8'h00;
        endcase
        case (n_q[1:0])
            2'd2:    ip_byte = LOCAL_IP[31:24];
            2'd3:    ip_byte = LOCAL_IP[23:16];
            2'd0:    ip_byte = LOCAL_IP[15:8];
            default: ip_byte = LOCAL_IP[7:0];
        endcase
    end

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        crc_d       = crc_q;
        sha_d       = sha_q;
        spa_d       = spa_q;
        req_d       = req_q;
        bc_d        = bc_q;
        uc_d        = uc_q;
        arp_valid_d = 1'b0;
        drop_d      = 1'b0;
        is_req_d    = is_req_q;
        peer_mac_d  = peer_mac_q;
        peer_ip_d   = peer_ip_q;
        crc_next    = crc_byte(crc_q, rx_data);
        field_ok    = 1'b1;
        bc_now      = bc_q;
        uc_now      = uc_q;

        if (rx_en) begin
            crc_d = crc_next;
            n_d   = (n_q == 11'd2047) ? n_q : n_q + 11'd1;

            // IDLE consumes the first byte exactly like HDR at n0.
            if (state_q == IDLE || state_q == HDR) begin
                case (n_q)
                    11'd0, 11'd1, 11'd2, 11'd3, 11'd4, 11'd5: begin
                        bc_now   = bc_q && (rx_data == 8'hFF);
                        uc_now   = uc_q && (rx_data == mac_byte);
                        bc_d     = bc_now;
                        uc_d     = uc_now;
                        field_ok = bc_now || uc_now;
                    end
                    11'd12: field_ok = (rx_data == 8'h08);
                    11'd13: field_ok = (rx_data == 8'h06);
                    11'd14: field_ok = (rx_data == 8'h00);
                    11'd15: field_ok = (rx_data == 8'h01);
                    11'd16: field_ok = (rx_data == 8'h08);
                    11'd17: field_ok = (rx_data == 8'h00);
                    11'd18: field_ok = (rx_data == 8'h06);
                    11'd19: field_ok = (rx_data == 8'h04);
                    11'd20: field_ok = (rx_data == 8'h00);
                    11'd21: begin
                        field_ok = (rx_data == 8'h01) || (rx_data == 8'h02);
                        req_d    = (rx_data == 8'h01);
                    end
                    11'd22, 11'd23, 11'd24, 11'd25, 11'd26, 11'd27:
                        sha_d = {sha_q[39:0], rx_data};
                    11'd28, 11'd29, 11'd30, 11'd31:
                        spa_d = {spa_q[23:0], rx_data};
                    11'd38, 11'd39, 11'd40, 11'd41:
                        field_ok = (rx_data == ip_byte);
                    default: ;
                endcase
                if (!field_ok) begin
                    state_d = DROP;
                end else if (n_q == 11'd41) begin
                    state_d = TAIL;
                end else begin
                    state_d = HDR;
                end
            end

            // A valid FCS leaves the characteristic CRC residue; length 64..1518 means n 63..1517.
            if (rx_last) begin
                if (state_q == TAIL && crc_next == 32'hDEBB20E3 &&
                    n_q >= 11'd63 && n_q <= 11'd1517) begin
                    arp_valid_d = 1'b1;
                    is_req_d    = req_q;
                    peer_mac_d  = sha_q;
                    peer_ip_d   = spa_q;
                end else begin
                    drop_d = 1'b1;
                end
                state_d = IDLE;
                n_d     = 11'd0;
                crc_d   = 32'hFFFFFFFF;
                bc_d    = 1'b1;
                uc_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= IDLE;
            n_q         <= 11'd0;
            crc_q       <= 32'hFFFFFFFF;
            sha_q       <= 48'h0;
            spa_q       <= 32'h0;
            req_q       <= 1'b0;
            bc_q        <= 1'b1;
            uc_q        <= 1'b1;
            arp_valid_q <= 1'b0;
            drop_q      <= 1'b0;
            is_req_q    <= 1'b0;
            peer_mac_q  <= 48'h0;
            peer_ip_q   <= 32'h0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            crc_q       <= crc_d;
            sha_q       <= sha_d;
            spa_q       <= spa_d;
            req_q       <= req_d;
            bc_q        <= bc_d;
            uc_q        <= uc_d;
            arp_valid_q <= arp_valid_d;
            drop_q      <= drop_d;
            is_req_q    <= is_req_d;
            peer_mac_q  <= peer_mac_d;
            peer_ip_q   <= peer_ip_d;
        end
    end

    assign arp_valid  = arp_valid_q;
    assign drop       = drop_q;
    assign arp_is_req = is_req_q;
    assign peer_mac   = peer_mac_q;
    assign peer_ip    = peer_ip_q;

endmodule

// File: tb/tb_arp_receiver.sv
// Self-checking bench for arp_receiver: frames are built and judged by a frame-level
// model, and a per-cycle compare process checks every output against that model.
module tb_arp_receiver;

    localparam logic [47:0] MAC = 48'h0A1B2C3D4E5F;
    localparam logic [31:0] IP  = 32'hC0A80101;

    typedef logic [7:0] bytes_t[$];
    typedef struct packed {
        logic        accept;
        logic        isReq;
        logic [47:0] mac;
        logic [31:0] ip;
    } exp_t;

    logic        clk = 1'b0;
    logic        clr;
    logic        rxEn;
    logic [7:0]  rxData;
    logic        rxLast;
    logic        arpValid;
    logic        arpIsReq;
    logic [47:0] peerMac;
    logic [31:0] peerIp;
    logic        dropOut;

    int   checks = 0;
    int   errors = 0;
    exp_t expQ[$];

    logic        modelValid = 1'b0;
    logic        modelDrop = 1'b0;
    logic        modelReq = 1'b0;
    logic [47:0] modelMac = 48'h0;
    logic [31:0] modelIp = 32'h0;

    arp_receiver #(.LOCAL_MAC(MAC), .LOCAL_IP(IP)) dut (
        .clk        (clk),
        .clr        (clr),
        .rx_en      (rxEn),
        .rx_data    (rxData),
        .rx_last    (rxLast),
        .arp_valid  (arpValid),
        .arp_is_req (arpIsReq),
        .peer_mac   (peerMac),
        .peer_ip    (peerIp),
        .drop       (dropOut)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Standard Ethernet CRC-32 (final complement applied) over a byte list.
    function automatic logic [31:0] crc32(input bytes_t d);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (d[i]) begin
            c ^= {24'h0, d[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic void pushField(inout bytes_t f, input logic [47:0] v, input int nbytes);
        for (int i = nbytes - 1; i >= 0; i--) f.push_back(8'(v >> (8 * i)));
    endfunction

    function automatic bytes_t buildFrame(input bit bcast, input logic [15:0] op,
                                          input logic [47:0] sha, input logic [31:0] spa,
                                          input logic [31:0] tpa, input logic [15:0] etype,
                                          input int total, input int flipBit);
        bytes_t      f;
        logic [31:0] fcs;
        pushField(f, bcast ? 48'hFFFFFFFFFFFF : MAC, 6);
        pushField(f, 48'h0200000000AA, 6);
        pushField(f, {32'h0, etype}, 2);
        pushField(f, 48'h0001, 2);
        pushField(f, 48'h0800, 2);
        pushField(f, 48'h06, 1);
        pushField(f, 48'h04, 1);
        pushField(f, {32'h0, op}, 2);
        pushField(f, sha, 6);
        pushField(f, {16'h0, spa}, 4);
        pushField(f, 48'h111111111111, 6);
        pushField(f, {16'h0, tpa}, 4);
        while (f.size() < total - 4) f.push_back(8'h00);
        fcs = crc32(f);
        for (int i = 0; i < 4; i++) f.push_back(8'(fcs >> (8 * i)));
        if (flipBit >= 0) f[total - 4 + flipBit / 8] ^= 8'(1 << (flipBit % 8));
        return f;
    endfunction

    // Frame-level judgement straight from the acceptance rules.
    function automatic exp_t evaluate(input bytes_t f);
        exp_t        e;
        int          len;
        bit          ok;
        bit          allFf;
        bit          allMe;
        bytes_t      body;
        logic [31:0] rxFcs;
        len = f.size();
        e   = '0;
        ok  = (len >= 64) && (len <= 1518);
        if (ok) begin
            allFf = 1;
            allMe = 1;
            for (int i = 0; i < 6; i++) begin
                if (f[i] != 8'hFF) allFf = 0;
                if (f[i] != 8'(MAC >> (40 - 8 * i))) allMe = 0;
            end
            ok &= allFf || allMe;
            ok &= ({f[12], f[13]} == 16'h0806) && ({f[14], f[15]} == 16'h0001);
            ok &= ({f[16], f[17]} == 16'h0800) && (f[18] == 8'h06) && (f[19] == 8'h04);
            ok &= ({f[20], f[21]} == 16'h0001) || ({f[20], f[21]} == 16'h0002);
            ok &= ({f[38], f[39], f[40], f[41]} == IP);
            for (int i = 0; i < len - 4; i++) body.push_back(f[i]);
            rxFcs = {f[len-1], f[len-2], f[len-3], f[len-4]};
            ok &= (crc32(body) == rxFcs);
            e.isReq = ({f[20], f[21]} == 16'h0001);
            e.mac   = {f[22], f[23], f[24], f[25], f[26], f[27]};
            e.ip    = {f[28], f[29], f[30], f[31]};
        end
        e.accept = ok;
        return e;
    endfunction

    // Per-cycle compare: decide what the outputs must show after each edge, then check.
    always @(posedge clk) begin
        exp_t e;
        modelValid = 1'b0;
        modelDrop  = 1'b0;
        if (clr) begin
            modelReq = 1'b0;
            modelMac = 48'h0;
            modelIp  = 32'h0;
        end else if (rxEn && rxLast) begin
            if (expQ.size() == 0) begin
                checkOutput("frame_expected", 64'd1, 64'd0);
            end else begin
                e = expQ.pop_front();
                if (e.accept) begin
                    modelValid = 1'b1;
                    modelReq   = e.isReq;
                    modelMac   = e.mac;
                    modelIp    = e.ip;
                end else begin
                    modelDrop = 1'b1;
                end
            end
        end
        #1;
        checkOutput("arp_valid", {63'h0, arpValid}, {63'h0, modelValid});
        checkOutput("drop", {63'h0, dropOut}, {63'h0, modelDrop});
        checkOutput("arp_is_req", {63'h0, arpIsReq}, {63'h0, modelReq});
        checkOutput("peer_mac", {16'h0, peerMac}, {16'h0, modelMac});
        checkOutput("peer_ip", {32'h0, peerIp}, {32'h0, modelIp});
    end

    // Drive one frame byte by byte, with optional random gaps or a clr at byte abortAt.
    task automatic applyStimulus(input bytes_t f, input int maxGap, input int abortAt);
        if (abortAt < 0) expQ.push_back(evaluate(f));
        for (int i = 0; i < f.size(); i++) begin
            if (maxGap > 0) begin
                int g;
                g = $urandom_range(maxGap, 0);
                repeat (g) begin
                    @(negedge clk);
                    rxEn   = 1'b0;
                    rxData = 8'($urandom);
                    rxLast = 1'($urandom);
                end
            end
            @(negedge clk);
            if (i == abortAt) begin
                clr    = 1'b1;
                rxEn   = 1'b1;
                rxData = f[i];
                rxLast = 1'b0;
                @(negedge clk);
                clr  = 1'b0;
                rxEn = 1'b0;
                return;
            end
            rxEn   = 1'b1;
            rxData = f[i];
            rxLast = (i == f.size() - 1);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rxEn   = 1'b0;
            rxLast = 1'b0;
        end
    endtask

    initial begin
        bytes_t f;
        bytes_t g;
        bytes_t t;
        clr    = 1'b1;
        rxEn   = 1'b0;
        rxData = 8'h00;
        rxLast = 1'b0;
        repeat (3) @(negedge clk);
        clr = 1'b0;
        checkOutput("reset_arp_valid", {63'h0, arpValid}, 64'd0);
        checkOutput("reset_drop", {63'h0, dropOut}, 64'd0);
        checkOutput("reset_peer_mac", {16'h0, peerMac}, 64'd0);
        checkOutput("reset_peer_ip", {32'h0, peerIp}, 64'd0);

        t = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        checkOutput("model_crc_pin", {32'h0, crc32(t)}, 64'hCBF43926);

        $display("[TB] broadcast request");
        f = buildFrame(1, 16'h0001, 48'h020000000001, 32'hC0A8010A, IP, 16'h0806, 64, -1);
        applyStimulus(f, 0, -1);
        idle(3);
        checkOutput("lit_is_req", {63'h0, arpIsReq}, 64'd1);
        checkOutput("lit_peer_mac", {16'h0, peerMac}, 64'h0000020000000001);
        checkOutput("lit_peer_ip", {32'h0, peerIp}, 64'h00000000C0A8010A);

        $display("[TB] unicast reply with gaps");
        f = buildFrame(0, 16'h0002, 48'h020000000001, 32'hC0A8010A, IP, 16'h0806, 64, -1);
        applyStimulus(f, 3, -1);
        idle(3);
        checkOutput("lit_reply_is_req", {63'h0, arpIsReq}, 64'd0);

        $display("[TB] rejected frames");
        f = buildFrame(1, 16'h0001, 48'h02000000BEEF, 32'h0A000001, IP, 16'h0806, 64, 5);
        applyStimulus(f, 0, -1);
        idle(2);
        f = buildFrame(1, 16'h0001, 48'h02000000BEEF, 32'h0A000001, 32'hC0A80199, 16'h0806, 64, -1);
        applyStimulus(f, 0, -1);
        idle(2);
        f = buildFrame(1, 16'h0001, 48'h02000000BEEF, 32'h0A000001, IP, 16'h0800, 64, -1);
        applyStimulus(f, 1, -1);
        idle(2);
        t = {};
        for (int i = 0; i < 20; i++) t.push_back(f[i]);
        applyStimulus(t, 0, -1);
        idle(2);
        f = buildFrame(1, 16'h0001, 48'h02000000BEEF, 32'h0A000001, IP, 16'h0806, 63, -1);
        applyStimulus(f, 0, -1);
        idle(2);
        checkOutput("lit_kept_peer_mac", {16'h0, peerMac}, 64'h0000020000000001);

        $display("[TB] length boundaries");
        f = buildFrame(1, 16'h0002, 48'h020000001518, 32'h0A001518, IP, 16'h0806, 1518, -1);
        applyStimulus(f, 0, -1);
        idle(2);
        f = buildFrame(1, 16'h0001, 48'h020000001519, 32'h0A001519, IP, 16'h0806, 1519, -1);
        applyStimulus(f, 0, -1);
        idle(2);

        $display("[TB] clr mid-frame");
        f = buildFrame(1, 16'h0001, 48'h0200000000CC, 32'h0A0000CC, IP, 16'h0806, 64, -1);
        applyStimulus(f, 0, 30);
        f = buildFrame(1, 16'h0001, 48'h020000000002, 32'hC0A8010B, IP, 16'h0806, 64, -1);
        applyStimulus(f, 0, -1);
        idle(2);

        $display("[TB] back-to-back frames");
        f = buildFrame(1, 16'h0001, 48'h020000000003, 32'hC0A8010C, IP, 16'h0806, 64, -1);
        g = buildFrame(0, 16'h0002, 48'h020000000004, 32'hC0A8010D, IP, 16'h0806, 70, -1);
        applyStimulus(f, 0, -1);
        applyStimulus(g, 0, -1);
        idle(3);
        checkOutput("lit_b2b_peer_mac", {16'h0, peerMac}, 64'h0000020000000004);
        checkOutput("lit_b2b_peer_ip", {32'h0, peerIp}, 64'h00000000C0A8010D);
        checkOutput("pending_frames", 64'(expQ.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/arp_receiver.md
ARP_RECEIVER -- requirements
Module: arp_receiver

Interface
REQ-001 Parameter LOCAL_MAC, 48'h000000000000 default, own MAC (byte 0 = MSB); integrator sets it to sour_mac.
REQ-002 Parameter LOCAL_IP, 32'h00000000 default, own IPv4 address (byte 0 = MSB); integrator sets it to ip_sour.
REQ-003 clk  input  1  sole clock; all logic on posedge.
REQ-004 clr  input  1  reset, synchronous, active-high.
REQ-005 rx_en  input  1  rx_data carries a valid frame byte this cycle.
REQ-006 rx_data  input  8  frame byte; first byte = dest MAC byte 0 (no preamble/SFD).
REQ-007 rx_last  input  1  qualifies the final byte (last FCS byte); honoured only with rx_en=1.
REQ-008 arp_valid  output  1  one-cycle pulse: accepted ARP frame.
REQ-009 arp_is_req  output  1  accepted opcode: 1 = request (0x0001), 0 = reply (0x0002).
REQ-010 peer_mac  output  48  sender hardware address (SHA) of the accepted frame.
REQ-011 peer_ip  output  32  sender protocol address (SPA) of the accepted frame.
REQ-012 drop  output  1  one-cycle pulse: frame ended and was rejected.

Function
REQ-013 Byte index n counts accepted bytes (rx_en=1) from 0; 11-bit counter, saturates at 2047.
REQ-014 Cycles with rx_en=0 SHALL freeze all state; gaps of any length inside a frame are legal.
REQ-015 States: IDLE, HDR (n 0..41), TAIL (n >= 42), DROP; IDLE->HDR on first rx_en byte.
REQ-016 HDR field checks, multi-byte fields MSB first: n0-5 = FF..FF or LOCAL_MAC; n12-13 = 0x0806; n14-15 = 0x0001; n16-17 = 0x0800; n18 = 0x06; n19 = 0x04; n20-21 = 0x0001 or 0x0002; n38-41 = LOCAL_IP.
REQ-017 n6-11 (source MAC) and n32-37 (THA) SHALL be ignored.
REQ-018 n22-27 captured into a SHA shadow, n28-31 into an SPA shadow; peer_mac/peer_ip SHALL change only on arp_valid.
REQ-019 Any field mismatch SHALL move HDR->DROP on that byte; DROP ignores data until rx_last.
REQ-020 HDR->TAIL after byte 41 passes; TAIL consumes pad and FCS bytes.
REQ-021 CRC-32 (reflected poly 0xEDB88320, init 0xFFFFFFFF, LSB first) SHALL run over every byte from n0 through the last FCS byte; FCS is sent low byte first.
REQ-022 Frame accepted iff rx_last arrives in TAIL, CRC register after the last byte == 0xDEBB20E3, and total length is 64..1518 bytes.
REQ-023 On acceptance: arp_valid=1 the cycle after the rx_last byte; arp_is_req, peer_mac, peer_ip updated that same cycle.
REQ-024 On rejection (DROP, CRC fail, length out of range, rx_last in HDR): drop=1 the cycle after the rx_last byte; peer outputs unchanged.
REQ-025 Exactly one of arp_valid or drop SHALL pulse per frame; never both, never neither.
REQ-026 After the rx_last byte the FSM SHALL return to IDLE and clear n and the CRC; a byte in the very next cycle starts a new frame at n0.
REQ-027 Bytes beyond 1518 without rx_last: stay in current state, length check fails at rx_last.

Reset
REQ-028 clr=1 SHALL force IDLE, n=0, CRC=0xFFFFFFFF, arp_valid=0, drop=0, arp_is_req=0, peer_mac=0, peer_ip=0.
REQ-029 clr SHALL take priority over rx_en in the same cycle; a frame in progress is discarded with no pulse.
REQ-030 The first byte after clr deasserts is n0 of a new frame.

Verification
REQ-031 64-byte broadcast request, valid FCS, SHA=02:00:00:00:00:01, SPA=C0A8010A, TPA=LOCAL_IP -> arp_valid one cycle after rx_last, arp_is_req=1, peer_mac=0x020000000001, peer_ip=0xC0A8010A.
REQ-032 Same frame as a reply unicast to LOCAL_MAC with random rx_en gaps -> arp_valid, arp_is_req=0, identical peer values.
REQ-033 Valid frame with one flipped FCS bit -> drop pulse, arp_valid stays 0, peer outputs keep previous values.
REQ-034 TPA != LOCAL_IP, or ethertype 0x0800 -> drop at rx_last only; no earlier pulse.
REQ-035 clr asserted at n=30, then a full valid frame -> no pulse for the first frame, arp_valid for the second.
REQ-036 Two valid frames back-to-back with no idle cycle -> two arp_valid pulses, peer outputs holding the second frame's values.
